camera_tx: RTL and testbench
============================

# camera_tx

Synthesizable OV7670-style DVP transmitter: it takes 16-bit RGB565 pixels over a ready/valid stream and drives `vsync`, `href` and `p_data` with the byte ordering and framing that `camera_read` consumes. It is used as a loop-back source for `camera_read` in simulation and on the board, and as a sensor stand-in when no camera is fitted. All frame geometry is parameterized so benches can run tiny frames.

## Interface

Parameters:
- `H_ACTIVE`, 640, pixels per line (href high for 2*H_ACTIVE cycles)
- `H_BLANK`, 144, href-low cycles after each line's active bytes
- `V_ACTIVE`, 480, active lines per frame
- `VSYNC_LINES`, 3, lines with vsync high
- `V_BACK`, 17, blank lines after vsync
- `V_FRONT`, 10, blank lines after the last active line
- Derived: LINE_CYCLES = 2*H_ACTIVE + H_BLANK; every line, blank or active, lasts LINE_CYCLES cycles.

Ports:
- `p_clock` in 1: pixel byte clock; one byte per cycle.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: start or continue frames.
- `pixel_in` in 16: RGB565 pixel.
- `pixel_in_valid` in 1: pixel_in holds a valid pixel.
- `pixel_in_ready` out 1: a pixel is accepted this cycle if valid.
- `vsync` out 1: frame sync, active high.
- `href` out 1: line valid, high during active bytes.
- `p_data` out 8: byte bus.
- `frame_done` out 1: one-cycle pulse at frame end.
- `underflow` out 1: one-cycle pulse when a pixel slot had no valid input.

## Operation

- States: IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT.
- IDLE:
  - All outputs low.
  - If `enable`=1, go to VSYNC on the next cycle.
- VSYNC:
  - `vsync`=1 for VSYNC_LINES*LINE_CYCLES cycles, then go to VBACK.
- VBACK:
  - V_BACK*LINE_CYCLES cycles with vsync/href low.
  - Then go to ACTIVE with row=0 (V_BACK=0 enters ACTIVE directly).
- ACTIVE:
  - `href`=1 for 2*H_ACTIVE cycles.
  - Even byte index = high byte `pixel[15:8]`, odd byte index = low byte `pixel[7:0]`, matching camera_read assembly order.
  - Then go to HBLANK.
- HBLANK:
  - H_BLANK cycles with href low.
  - If row < V_ACTIVE-1: row++, back to ACTIVE.
  - Else go to VFRONT.
- VFRONT:
  - V_FRONT*LINE_CYCLES cycles.
  - Then go to VSYNC if `enable`=1, else IDLE.
  - `enable` is sampled only in IDLE and on the last VFRONT cycle; deasserting it mid-frame finishes the frame.
- Pixel fetch:
  - `pixel_in_ready`=1 exactly in the cycle before each high-byte cycle: the last VBACK cycle, the last HBLANK cycle of a non-final row, and every odd-byte ACTIVE cycle except the line's last byte.
  - On ready&valid, latch pixel_in into the hold register.
  - On ready&!valid, the next pixel is emitted as 0x0000 and `underflow` pulses in the cycle its high byte is driven.
  - The input stream is never stalled otherwise.
- `frame_done`: one-cycle pulse in the first HBLANK cycle of row V_ACTIVE-1, i.e. coincident with href falling on the last line.
- `p_data` is 0x00 whenever href=0.
- Counters: byte counter sized for max(LINE_CYCLES), line counter for max(VSYNC_LINES,V_BACK,V_FRONT,V_ACTIVE) lines; wrap-free since they are reset per state.

## Timing

- All outputs registered off `p_clock`. Reset values: vsync=0, href=0, p_data=0x00, pixel_in_ready=0, frame_done=0, underflow=0, state IDLE, hold register 0.
- Latency: pixel accepted at cycle t appears as high byte at t+1 and low byte at t+2.
- Frame period = (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)*LINE_CYCLES cycles. Back-to-back frames have no gap.
- Reset asserted mid-line: outputs drop to reset values asynchronously. After release, the block restarts from IDLE; no partial line resumes.

## Structure

- Shared package `camera_pkg`:
  - state encoding `tx_state_t`
  - RGB565 field widths
  - default geometry constants (640/480, blanking), also used by camera_read benches.
- One natural sub-module, `camera_tx_timing`: the state machine plus line/byte counters, emitting `in_active`, `byte_idx`, `fetch` and `last_line` strobes. The top adds the hold register, byte mux and pulse outputs.

## Test plan

Small geometry: H_ACTIVE=4, H_BLANK=3, V_ACTIVE=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, so LINE_CYCLES=11.

- Reset, then `enable`=1 with pixels 0x1234, 0x5678, … always valid:
  - vsync high 11 cycles
  - 11 blank cycles
  - href high 8 cycles with p_data 12,34,56,78,…
  - 3 low cycles, second line, `frame_done` pulse, 11 front cycles.
- `pixel_in_valid`=0 for the third pixel slot: that pixel is output as 00,00, `underflow` pulses once on its high byte, and the following pixel is correct.
- `enable` dropped during row 0: the frame completes, then the block returns to IDLE with all outputs low. Frame period check = 55 cycles.
- `enable` held high: a second vsync rises on the cycle right after the last VFRONT cycle, with no idle gap.
- `rst_n` low mid-ACTIVE: href/p_data/vsync are 0 immediately. After release with `enable`=1, a full fresh frame starts from VSYNC.
- Loop-back into camera_read: 2 frames of incrementing pixels are received bit-exact, with `pixel_valid` count = 8 per frame.

Source files
------------

// File: rtl/camera_pkg.sv
// -----------------------------------------------------------------------------
// camera_pkg
// Shared definitions for the DVP camera blocks: transmitter state encoding,
// RGB565 field widths and the default VGA frame geometry (also used by the
// camera_read benches). Small integer helpers size the frame counters.
// No ports.
// -----------------------------------------------------------------------------
package camera_pkg;

    // Transmitter frame-sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFRONT = 3'd5
    } tx_state_t;

    // RGB565 field widths, high byte first on the wire.
    localparam int RGB_R_W  = 5;
    localparam int RGB_G_W  = 6;
    localparam int RGB_B_W  = 5;
    localparam int RGB565_W = RGB_R_W + RGB_G_W + RGB_B_W;

    // Default 640x480 geometry with OV7670-like blanking.
    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_BLANK     = 144;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_VSYNC_LINES = 3;
    localparam int DEF_V_BACK      = 17;
    localparam int DEF_V_FRONT     = 10;

    // Bits needed to hold the values 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        if (n < 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    // Largest of four integers.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        if (d > m) begin
            m = d;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/camera_tx_timing.sv
// -----------------------------------------------------------------------------
// camera_tx_timing
// Frame sequencer for camera_tx: state machine plus byte and line counters.
// All strobes are registered and describe the current clock cycle.
// Ports:
//   p_clock, rst_n  : byte clock, asynchronous active-low reset
//   enable          : start/continue frames (sampled in IDLE and on the
//                     last cycle of the frame)
//   in_vsync        : cycle lies in the vsync lines
//   in_active       : cycle is an active (href) byte
//   byte_idx        : byte position inside the current line / blank segment
//   fetch           : cycle immediately before a high-byte cycle
//   last_line       : active/hblank cycle belongs to the final active row
// Assumes H_ACTIVE, H_BLANK, V_ACTIVE and VSYNC_LINES are all at least 1.
// -----------------------------------------------------------------------------
module camera_tx_timing
    import camera_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int BW          = 11,
    parameter int LW          = 9
) (
    input  logic          p_clock,
    input  logic          rst_n,
    input  logic          enable,
    output logic          in_vsync,
    output logic          in_active,
    output logic [BW-1:0] byte_idx,
    output logic          fetch,
    output logic          last_line
);

    localparam int LINE_CYCLES = 2 * H_ACTIVE + H_BLANK;

    localparam logic [BW-1:0] LINE_LAST = BW'(LINE_CYCLES - 1);
    localparam logic [BW-1:0] ACT_LAST  = BW'(2 * H_ACTIVE - 1);
    localparam logic [BW-1:0] HBL_LAST  = BW'(H_BLANK - 1);
    localparam logic [LW-1:0] VS_LAST   = LW'(VSYNC_LINES - 1);
    localparam logic [LW-1:0] VB_LAST   = LW'(V_BACK - 1);
    localparam logic [LW-1:0] VA_LAST   = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] VF_LAST   = LW'(V_FRONT - 1);

    tx_state_t     state_r, state_s;
    logic [BW-1:0] byte_r, byte_s;
    logic [LW-1:0] line_r, line_s;
    logic          in_vsync_r, in_active_r, fetch_r, last_line_r;
    logic          fetch_n_s, last_line_n_s;

    // Next-state and counter update logic.
    always_comb begin
        state_s = state_r;
        byte_s  = byte_r + BW'(1);
        line_s  = line_r;
        case (state_r)
            ST_IDLE: begin
                byte_s = BW'(0);
                line_s = LW'(0);
                if (enable) begin
                    state_s = ST_VSYNC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_VSYNC: begin
                if (byte_r == LINE_LAST) begin
                    byte_s = BW'(0);
                    if (line_r == VS_LAST) begin
                        line_s = LW'(0);
                        // With no back porch the first active row follows vsync.
                        if (V_BACK == 0) begin
                            state_s = ST_ACTIVE;
                        end else begin
                            state_s = ST_VBACK;
                        end
                    end else begin
                        line_s = line_r + LW'(1);
                    end
                end else begin
                    byte_s = byte_r + BW'(1);
                end
            end
            ST_VBACK: begin
                if (byte_r == LINE_LAST) begin
                    byte_s = BW'(0);
                    if (line_r == VB_LAST) begin
                        line_s  = LW'(0);
                        state_s = ST_ACTIVE;
                    end else begin
                        line_s = line_r + LW'(1);
                    end
                end else begin
                    byte_s = byte_r + BW'(1);
                end
            end
            ST_ACTIVE: begin
                if (byte_r == ACT_LAST) begin
                    byte_s  = BW'(0);
                    state_s = ST_HBLANK;
                end else begin
                    byte_s = byte_r + BW'(1);
                end
            end
            ST_HBLANK: begin
                if (byte_r == HBL_LAST) begin
                    byte_s = BW'(0);
                    if (line_r != VA_LAST) begin
                        line_s  = line_r + LW'(1);
                        state_s = ST_ACTIVE;
                    end else begin
                        line_s = LW'(0);
                        if (V_FRONT != 0) begin
                            state_s = ST_VFRONT;
                        end else if (enable) begin
                            state_s = ST_VSYNC;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end
                end else begin
                    byte_s = byte_r + BW'(1);
                end
            end
            ST_VFRONT: begin
                if (byte_r == LINE_LAST) begin
                    byte_s = BW'(0);
                    if (line_r == VF_LAST) begin
                        line_s = LW'(0);
                        // Frame boundary: the only mid-run point enable is looked at.
                        if (enable) begin
                            state_s = ST_VSYNC;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        line_s = line_r + LW'(1);
                    end
                end else begin
                    byte_s = byte_r + BW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                byte_s  = BW'(0);
                line_s  = LW'(0);
            end
        endcase
    end

    // Strobes for the upcoming cycle, derived from the next counter values so
    // that the registered versions line up with the cycle they describe.
    always_comb begin
        fetch_n_s     = 1'b0;
        last_line_n_s = 1'b0;
        case (state_s)
            ST_VSYNC: begin
                fetch_n_s = (V_BACK == 0) && (byte_s == LINE_LAST) && (line_s == VS_LAST);
            end
            ST_VBACK: begin
                fetch_n_s = (byte_s == LINE_LAST) && (line_s == VB_LAST);
            end
            ST_ACTIVE: begin
                // Odd bytes prefetch the next pixel, except the line's final byte.
                fetch_n_s     = byte_s[0] && (byte_s != ACT_LAST);
                last_line_n_s = (line_s == VA_LAST);
            end
            ST_HBLANK: begin
                fetch_n_s     = (byte_s == HBL_LAST) && (line_s != VA_LAST);
                last_line_n_s = (line_s == VA_LAST);
            end
            default: begin
                fetch_n_s     = 1'b0;
                last_line_n_s = 1'b0;
            end
        endcase
    end

    // State, counters and strobe registers.
    always_ff @(posedge p_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            byte_r      <= BW'(0);
            line_r      <= LW'(0);
            in_vsync_r  <= 1'b0;
            in_active_r <= 1'b0;
            fetch_r     <= 1'b0;
            last_line_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            byte_r      <= byte_s;
            line_r      <= line_s;
            in_vsync_r  <= (state_s == ST_VSYNC);
            in_active_r <= (state_s == ST_ACTIVE);
            fetch_r     <= fetch_n_s;
            last_line_r <= last_line_n_s;
        end
    end

    assign in_vsync  = in_vsync_r;
    assign in_active = in_active_r;
    assign byte_idx  = byte_r;
    assign fetch     = fetch_r;
    assign last_line = last_line_r;

endmodule

// File: rtl/camera_tx.sv
// -----------------------------------------------------------------------------
// camera_tx
// OV7670-style DVP transmitter. Takes RGB565 pixels over ready/valid and
// drives vsync/href/p_data, high byte first, for loop-back into camera_read.
// Ports:
//   p_clock, rst_n   : byte clock, asynchronous active-low reset
//   enable           : start or continue frames
//   pixel_in         : RGB565 pixel
//   pixel_in_valid   : pixel_in holds a pixel
//   pixel_in_ready   : a pixel is taken this cycle if valid
//   vsync, href      : frame sync / line valid
//   p_data           : byte bus, zero whenever href is low
//   frame_done       : one-cycle pulse as href falls on the last row
//   underflow        : one-cycle pulse on the high byte of a missing pixel
// -----------------------------------------------------------------------------
module camera_tx
    import camera_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_FRONT     = DEF_V_FRONT
) (
    input  logic                p_clock,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [RGB565_W-1:0] pixel_in,
    input  logic                pixel_in_valid,
    output logic                pixel_in_ready,
    output logic                vsync,
    output logic                href,
    output logic [7:0]          p_data,
    output logic                frame_done,
    output logic                underflow
);

    localparam int LINE_CYCLES = 2 * H_ACTIVE + H_BLANK;
    localparam int BW = cnt_width(LINE_CYCLES);
    localparam int LW = cnt_width(max4(VSYNC_LINES, V_BACK, V_FRONT, V_ACTIVE));
    localparam logic [BW-1:0] ACT_LAST = BW'(2 * H_ACTIVE - 1);

    logic                in_vsync_s, in_active_s, fetch_s, last_line_s;
    logic [BW-1:0]       byte_idx_s;
    logic [RGB565_W-1:0] hold_r, hold_s;
    logic [7:0]          p_data_r, p_data_s;
    logic                frame_done_r, underflow_r;

    camera_tx_timing #(
        .H_ACTIVE    (H_ACTIVE),
        .H_BLANK     (H_BLANK),
        .V_ACTIVE    (V_ACTIVE),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT),
        .BW          (BW),
        .LW          (LW)
    ) u_timing (
        .p_clock   (p_clock),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_vsync  (in_vsync_s),
        .in_active (in_active_s),
        .byte_idx  (byte_idx_s),
        .fetch     (fetch_s),
        .last_line (last_line_s)
    );

    // Byte for the next cycle. A fetch cycle is always followed by a high
    // byte, which is taken straight from the input so it appears one cycle
    // after acceptance; the low byte then comes from the hold register.
    always_comb begin
        hold_s   = hold_r;
        p_data_s = 8'h00;
        if (fetch_s) begin
            if (pixel_in_valid) begin
                hold_s   = pixel_in;
                p_data_s = pixel_in[RGB565_W-1:8];
            end else begin
                hold_s   = {RGB565_W{1'b0}};
                p_data_s = 8'h00;
            end
        end else if (in_active_s && !byte_idx_s[0]) begin
            p_data_s = hold_r[7:0];
        end else begin
            p_data_s = 8'h00;
        end
    end

    // Hold register, byte bus and pulse outputs.
    always_ff @(posedge p_clock or negedge rst_n) begin
        if (!rst_n) begin
            hold_r       <= {RGB565_W{1'b0}};
            p_data_r     <= 8'h00;
            frame_done_r <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            hold_r       <= hold_s;
            p_data_r     <= p_data_s;
            // Last byte of the last row: the pulse lands as href falls.
            frame_done_r <= in_active_s && last_line_s && (byte_idx_s == ACT_LAST);
            underflow_r  <= fetch_s && !pixel_in_valid;
        end
    end

    assign pixel_in_ready = fetch_s;
    assign vsync          = in_vsync_s;
    assign href           = in_active_s;
    assign p_data         = p_data_r;
    assign frame_done     = frame_done_r;
    assign underflow      = underflow_r;

endmodule

// File: tb/tb_camera_tx.sv
// -----------------------------------------------------------------------------
// tb_camera_tx
// Self-checking bench for camera_tx on a tiny 4x2 frame. Expected outputs are
// computed from the frame position (line/column arithmetic) and from the pixels
// the bench itself offered; a table of eight pixel slots carries fixed
// expected bytes for the first frame.
// -----------------------------------------------------------------------------
module tb_camera_tx;

    localparam int H     = 4;
    localparam int HB    = 3;
    localparam int VA    = 2;
    localparam int VS    = 1;
    localparam int VB    = 1;
    localparam int VF    = 1;
    localparam int LC    = 2 * H + HB;
    localparam int FRAME = (VS + VB + VA + VF) * LC;
    localparam int NPIX  = H * VA;

    logic        p_clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] pixel_in = 16'h0000;
    logic        pixel_in_valid = 1'b0;
    logic        pixel_in_ready, vsync, href, frame_done, underflow;
    logic [7:0]  p_data;

    camera_tx #(
        .H_ACTIVE(H), .H_BLANK(HB), .V_ACTIVE(VA),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .p_clock        (p_clock),
        .rst_n          (rst_n),
        .enable         (enable),
        .pixel_in       (pixel_in),
        .pixel_in_valid (pixel_in_valid),
        .pixel_in_ready (pixel_in_ready),
        .vsync          (vsync),
        .href           (href),
        .p_data         (p_data),
        .frame_done     (frame_done),
        .underflow      (underflow)
    );

    always #5 p_clock = ~p_clock;

    int cyc = 0;
    always @(posedge p_clock) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int start_cyc = 0;

    logic [15:0] exp_pix [NPIX];
    logic        exp_uf  [NPIX];

    typedef struct {
        logic        valid;
        logic [15:0] pix;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic        uf;
    } slot_vec_t;
    slot_vec_t tbl [NPIX];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [12:0] outs();
        return {vsync, href, p_data, pixel_in_ready, frame_done, underflow};
    endfunction

    // Pixel slot whose high byte is sent at frame position p, else -1.
    function automatic int hi_slot(input int p);
        int line, col, r;
        if (p < 0 || p >= FRAME) return -1;
        line = p / LC;
        col  = p % LC;
        r    = line - VS - VB;
        if (r >= 0 && r < VA && col < 2 * H && (col % 2) == 0) return r * H + col / 2;
        return -1;
    endfunction

    function automatic int lo_slot(input int p);
        int line, col, r;
        if (p < 0 || p >= FRAME) return -1;
        line = p / LC;
        col  = p % LC;
        r    = line - VS - VB;
        if (r >= 0 && r < VA && col < 2 * H && (col % 2) == 1) return r * H + col / 2;
        return -1;
    endfunction

    task automatic idle_cycles(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(posedge p_clock); #1;
            pixel_in_valid = 1'($urandom_range(0, 1));
            pixel_in       = 16'($urandom);
            @(negedge p_clock);
            check(name, 32'(outs()), 32'd0);
        end
    endtask

    // One frame starting at its first vsync cycle. mode 0 takes pixels from
    // the table, mode 1 offers random pixels with random gaps. enable drops
    // from position drop_p on; the frame is abandoned after position stop_p.
    task automatic run_frame(input int mode, input int drop_p, input int stop_p);
        int s, h, l, line, col;
        logic [12:0] want_v;
        logic e_vs, e_href, e_rdy, e_fd, e_uf;
        logic [7:0] e_data;
        for (int p = 0; p < FRAME; p++) begin
            @(posedge p_clock); #1;
            if (p == 0) start_cyc = cyc;
            if (p >= drop_p) enable = 1'b0;
            s = hi_slot(p + 1);
            if (s >= 0) begin
                if (mode == 0) begin
                    pixel_in_valid = tbl[s].valid;
                    pixel_in       = tbl[s].pix;
                end else begin
                    pixel_in_valid = ($urandom_range(0, 3) != 0);
                    pixel_in       = 16'($urandom);
                end
                exp_pix[s] = pixel_in_valid ? pixel_in : 16'h0000;
                exp_uf[s]  = !pixel_in_valid;
            end else begin
                pixel_in_valid = 1'($urandom_range(0, 1));
                pixel_in       = 16'($urandom);
            end
            @(negedge p_clock);
            line   = p / LC;
            col    = p % LC;
            h      = hi_slot(p);
            l      = lo_slot(p);
            e_vs   = (line < VS);
            e_href = (h >= 0) || (l >= 0);
            if (h >= 0)      e_data = exp_pix[h][15:8];
            else if (l >= 0) e_data = exp_pix[l][7:0];
            else             e_data = 8'h00;
            e_rdy  = (hi_slot(p + 1) >= 0);
            e_fd   = (line == VS + VB + VA - 1) && (col == 2 * H);
            e_uf   = (h >= 0) && exp_uf[h];
            want_v = {e_vs, e_href, e_data, e_rdy, e_fd, e_uf};
            check("cycle", 32'(outs()), 32'(want_v));
            if (mode == 0 && h >= 0)
                check("tbl_hi", 32'({underflow, p_data}), 32'({tbl[h].uf, tbl[h].hi}));
            if (mode == 0 && l >= 0)
                check("tbl_lo", 32'(p_data), 32'(tbl[l].lo));
            if (p == stop_p) break;
        end
    endtask

    // Spend one IDLE cycle with enable raised so the next cycle starts a frame.
    task automatic arm();
        @(posedge p_clock); #1;
        enable = 1'b1;
        @(negedge p_clock);
        check("arm_idle", 32'(outs()), 32'd0);
    endtask

    initial begin
        int s1;
        tbl[0] = '{1'b1, 16'h1234, 8'h12, 8'h34, 1'b0};
        tbl[1] = '{1'b1, 16'h5678, 8'h56, 8'h78, 1'b0};
        tbl[2] = '{1'b0, 16'hDEAD, 8'h00, 8'h00, 1'b1};
        tbl[3] = '{1'b1, 16'h9ABC, 8'h9A, 8'hBC, 1'b0};
        tbl[4] = '{1'b1, 16'hDEF0, 8'hDE, 8'hF0, 1'b0};
        tbl[5] = '{1'b1, 16'h1357, 8'h13, 8'h57, 1'b0};
        tbl[6] = '{1'b1, 16'h2468, 8'h24, 8'h68, 1'b0};
        tbl[7] = '{1'b1, 16'hACE1, 8'hAC, 8'hE1, 1'b0};

        // Reset state, then idle with enable low.
        repeat (2) @(negedge p_clock);
        check("reset", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        idle_cycles(2, "idle");

        // Table frame followed back-to-back by a frame whose enable drops in row 0.
        arm();
        run_frame(0, FRAME, -1);
        s1 = start_cyc;
        run_frame(1, (VS + VB) * LC + 2, -1);
        check("period", 32'(start_cyc - s1), 32'(FRAME));
        idle_cycles(4, "idle_after");

        // Continuous frames, then reset in the middle of the second active row.
        arm();
        run_frame(1, FRAME, -1);
        s1 = start_cyc;
        run_frame(1, FRAME, -1);
        check("period2", 32'(start_cyc - s1), 32'(FRAME));
        run_frame(1, FRAME, (VS + VB + 1) * LC + 3);
        check("pre_rst_href", 32'(href), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 32'(outs()), 32'd0);
        @(posedge p_clock);
        @(negedge p_clock);
        check("rst_hold", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        #1 check("rst_release", 32'(outs()), 32'd0);
        run_frame(1, 5, -1);
        idle_cycles(3, "idle_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
